// File: rtl/dma_cmd_arbiter_pkg.sv
// Shared types and limits for the debug DMA command arbiter.
package dma_cmd_arbiter_pkg;

    localparam int DMA_ARB_MAXREQ = 4;
    localparam int DMA_ARB_PTRW   = $clog2(DMA_ARB_MAXREQ);
    localparam int DEBUG_DMA_CMDW = 64;

    typedef logic [DEBUG_DMA_CMDW-1:0] debug_dma_cmdif_in_type;
    typedef debug_dma_cmdif_in_type    dma_cmd_word_type;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE
    } dma_arb_state_type;

endpackage

// File: rtl/dma_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer, wrapping.
module dma_rr_pick
    import dma_cmd_arbiter_pkg::*;
#(
    parameter int NREQ = 2
)
(
    input  logic [NREQ-1:0]         i_req,
    input  logic [DMA_ARB_PTRW-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt,
    output logic [DMA_ARB_PTRW-1:0] o_idx
);

    logic            w_found;
    logic [NREQ-1:0] w_bit;
    int              w_slot;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_bit   = '0;
        w_slot  = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Pointer is always below NREQ, so a single wrap subtraction suffices.
            w_slot = int'(i_ptr) + k;
            if (w_slot >= NREQ) begin
                w_slot = w_slot - NREQ;
            end
            w_bit = NREQ'(1) << w_slot;
            if (!w_found && (|(i_req & w_bit))) begin
                w_found = 1'b1;
                o_gnt   = w_bit;
                o_idx   = DMA_ARB_PTRW'(w_slot);
            end
        end
    end

endmodule

// File: rtl/dma_cmd_arbiter.sv
// Round-robin owner of the debug DMA command interface; grant held until dma_done.
// Optional watchdog abort is built when DMA_ARB_TIMEOUT_EN is defined.
//   state   | meaning
//   IDLE    | no owner; arbitrate among req
//   ISSUE   | dma_cmd_valid high, waiting for dma_cmd_ack
//   WAIT    | command accepted, waiting for dma_done
//   RELEASE | one cycle: gnt_done (or gnt_err) to owner, pointer advances
module dma_cmd_arbiter
    import dma_cmd_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CMDW = 64,
    parameter int TOW  = 16
)
(
    input  logic                 gclk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CMDW-1:0] req_cmd,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      gnt_done,
    output logic [NREQ-1:0]      gnt_err,
    output logic                 dma_cmd_valid,
    output logic [CMDW-1:0]      dma_cmd,
    input  logic                 dma_cmd_ack,
    input  logic                 dma_done,
    output logic                 busy
);

    if (NREQ < 2 || NREQ > DMA_ARB_MAXREQ || TOW < 2) begin : g_param_chk
        $error("dma_cmd_arbiter: unsupported NREQ or TOW");
    end

    dma_arb_state_type       r_state;
    dma_arb_state_type       w_state_nxt;
    logic [DMA_ARB_PTRW-1:0] r_ptr;
    logic [DMA_ARB_PTRW-1:0] r_owner;
    logic [NREQ-1:0]         r_gnt;
    logic [CMDW-1:0]         r_cmd;
    logic [NREQ-1:0]         w_pick_gnt;
    logic [DMA_ARB_PTRW-1:0] w_pick_idx;
    logic [CMDW-1:0]         w_sel_cmd;
    logic                    w_abort;
    logic                    w_err;

    dma_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    always_comb begin
        w_sel_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_gnt[i]) begin
                w_sel_cmd = req_cmd[i*CMDW +: CMDW];
            end
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    logic [TOW-1:0] r_wd;
    logic [TOW-1:0] w_wd_nxt;
    logic           r_err;

    // Saturating count so an abort still fires if the last step landed on an ack.
    assign w_wd_nxt = (r_wd == '1) ? r_wd : r_wd + 1'b1;
    assign w_err    = r_err;

    always_ff @(posedge gclk) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (r_state == ISSUE || r_state == WAIT) begin
                r_wd <= w_wd_nxt;
            end else begin
                r_wd <= '0;
            end
        end
    end
`else
    assign w_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_abort       = 1'b0;
        gnt           = r_gnt;
        gnt_done      = '0;
        gnt_err       = '0;
        dma_cmd_valid = 1'b0;
        dma_cmd       = r_cmd;
        busy          = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dma_cmd_valid = 1'b1;
                if (dma_cmd_ack && dma_done) begin
                    w_state_nxt = RELEASE;
                end else if (dma_cmd_ack) begin
                    w_state_nxt = WAIT;
                end
`ifdef DMA_ARB_TIMEOUT_EN
                else if (w_wd_nxt == '1) begin
                    w_state_nxt = RELEASE;
                    w_abort     = 1'b1;
                end
`endif
            end
            WAIT: begin
                if (dma_done) begin
                    w_state_nxt = RELEASE;
                end
`ifdef DMA_ARB_TIMEOUT_EN
                else if (w_wd_nxt == '1) begin
                    w_state_nxt = RELEASE;
                    w_abort     = 1'b1;
                end
`endif
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                if (w_err) begin
                    gnt_err = r_gnt;
                end else begin
                    gnt_done = r_gnt;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && (|req)) begin
                r_gnt   <= w_pick_gnt;
                r_owner <= w_pick_idx;
                r_cmd   <= w_sel_cmd;
            end
            if (r_state == RELEASE) begin
                r_gnt <= '0;
                r_cmd <= '0;
                r_ptr <= (r_owner == DMA_ARB_PTRW'(NREQ-1)) ? '0 : r_owner + 1'b1;
            end
        end
    end

endmodule
